pipelined_right_shifter: RTL and testbench

Registered, variable-amount right shifter for N-bit words, built as a log2(N)-stage pipeline. Stage k shifts by 2^k when bit k of the shift amount is set. The block supports logical and arithmetic modes with valid/ready handshakes on both sides. It extends the constant-shift combinational modules to a runtime shift amount and is the shift stage feeding the downstream normalisation and accumulate logic.

---
 rtl/pipelined_right_shifter_if.sv | 27 ++
 rtl/pipelined_right_shifter.sv | 77 +++++++
 tb/tb_pipelined_right_shifter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_right_shifter_if.sv
// Handshake bundle for pipelined_right_shifter: up_* request channel,
// down_* result channel; master = producer/consumer side, slave = shifter.
interface pipelined_right_shifter_if #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
);
  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_shamt;
  logic          up_arith;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;

  modport master (
    output up_valid, up_data, up_shamt,
    output up_arith, down_ready,
    input  up_ready, down_valid, down_data
  );

  modport slave (
    input  up_valid, up_data, up_shamt,
    input  up_arith, down_ready,
    output up_ready, down_valid, down_data
  );
endinterface

// File: rtl/pipelined_right_shifter.sv
// log2(N)-stage registered right shifter, logical/arithmetic, valid/ready.
// Ports: clk, rst_n (async low), bus (slave: up_* request, down_* result).
module pipelined_right_shifter #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input logic                      clk,
  input logic                      rst_n,
  pipelined_right_shifter_if.slave bus
);

  logic w_stall;

  for (genvar k = 0; k < SW; k++) begin : g_st
    localparam int S = 1 << k;

    logic            w_v;
    logic            w_a;
    logic [N-1:0]    w_d;
    logic [SW-k-1:0] w_s;
    logic            w_fill;
    logic [N-1:0]    w_q;
    logic            r_v;
    logic [N-1:0]    r_d;

    if (k == 0) begin : g_src
      assign w_v = bus.up_valid;
      assign w_a = bus.up_arith;
      assign w_d = bus.up_data;
      assign w_s = bus.up_shamt;
    end else begin : g_src
      assign w_v = g_st[k-1].r_v;
      assign w_a = g_st[k-1].g_fwd.r_a;
      assign w_d = g_st[k-1].r_d;
      assign w_s = g_st[k-1].g_fwd.r_s;
    end

    // MSB of the stage input still equals the original sign
    assign w_fill = w_a & w_d[N-1];
    assign w_q = w_s[0] ? {{S{w_fill}}, w_d[N-1:S]}
                        : w_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else if (!w_stall) begin
        r_v <= w_v;
        r_d <= w_q;
      end
    end

    // bit 0 is consumed here; the last stage keeps no shamt/arith
    if (k < SW - 1) begin : g_fwd
      logic            r_a;
      logic [SW-k-2:0] r_s;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= 1'b0;
          r_s <= '0;
        end else if (!w_stall) begin
          r_a <= w_a;
          r_s <= w_s[SW-k-1:1];
        end
      end
    end
  end

  assign bus.down_valid = g_st[SW-1].r_v;
  assign bus.down_data  = g_st[SW-1].r_d;

  // global stall: the whole pipe freezes, bubbles included
  assign w_stall      = bus.down_valid & ~bus.down_ready;
  assign bus.up_ready = ~w_stall;

endmodule

// File: tb/tb_pipelined_right_shifter.sv
// Self-checking bench for pipelined_right_shifter (N=8).
// Scoreboard queue filled on acceptance, drained on delivery.
module tb_pipelined_right_shifter;
  localparam int N  = 8;
  localparam int SW = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic bp_en;
  logic rdy_val;
  logic          prev_stall;
  logic [N-1:0]  prev_data;
  logic [N-1:0]  q[$];

  pipelined_right_shifter_if #(.N(N)) bus ();

  pipelined_right_shifter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model(
    input logic [N-1:0] a,
    input logic [SW-1:0] s,
    input logic ar);
    logic signed [N-1:0] sa;
    sa = a;
    if (ar) model = sa >>> s;
    else    model = a >> s;
  endfunction

  // down_ready owner: random when bp_en, else rdy_val
  always @(posedge clk) begin
    #1;
    if (bp_en) bus.down_ready = ($urandom_range(0, 9) >= 3);
    else       bus.down_ready = rdy_val;
  end

  // scoreboard and protocol monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, bus.down_valid}, 1);
        chk("stall_data", {24'd0, bus.down_data},
            {24'd0, prev_data});
      end
      chk("up_ready", {31'd0, bus.up_ready},
          {31'd0, ~(bus.down_valid & ~bus.down_ready)});
      if (bus.down_valid && bus.down_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {24'd0, bus.down_data}, 32'hDEAD);
        end else begin
          chk("result", {24'd0, bus.down_data},
              {24'd0, q.pop_front()});
        end
      end
      prev_stall = bus.down_valid & ~bus.down_ready;
      prev_data  = bus.down_data;
    end
  end

  task automatic send(input logic [N-1:0] a,
                      input logic [SW-1:0] s,
                      input logic ar,
                      input logic [N-1:0] exp);
    logic acc;
    int   n;
    bus.up_valid = 1'b1;
    bus.up_data  = a;
    bus.up_shamt = s;
    bus.up_arith = ar;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = bus.up_ready;
      if (acc) q.push_back(exp);
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int c);
    bus.up_valid = 1'b0;
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bp_en = 1'b0;
    rdy_val = 1'b1;
    prev_stall = 1'b0;
    bus.up_valid = 1'b0;
    bus.up_data = '0;
    bus.up_shamt = '0;
    bus.up_arith = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, bus.down_valid}, 0);
    chk("rst_data", {24'd0, bus.down_data}, 0);
    chk("rst_ready", {31'd0, bus.up_ready}, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // latency: valid appears two edges after the accept edge
    send(8'b1011_0110, 3'd3, 1'b0, 8'b0001_0110);
    bus.up_valid = 1'b0;
    @(negedge clk);
    chk("lat_t0", {31'd0, bus.down_valid}, 0);
    @(negedge clk);
    chk("lat_t1", {31'd0, bus.down_valid}, 0);
    @(negedge clk);
    chk("lat_t2", {31'd0, bus.down_valid}, 1);
    chk("lat_data", {24'd0, bus.down_data}, 8'b0001_0110);
    @(posedge clk);
    #1;

    send(8'b1011_0110, 3'd3, 1'b1, 8'b1111_0110);
    send(8'b0111_0000, 3'd7, 1'b1, 8'b0000_0000);
    send(8'b1000_0000, 3'd7, 1'b1, 8'b1111_1111);
    send(8'hFF, 3'd7, 1'b0, 8'h01);
    send(8'hFF, 3'd7, 1'b1, 8'hFF);
    send(8'hA5, 3'd0, 1'b0, 8'hA5);
    send(8'hA5, 3'd0, 1'b1, 8'hA5);
    send(8'h80, 3'd1, 1'b1, 8'hC0);
    send(8'h80, 3'd4, 1'b0, 8'h08);
    idle(1);
    drain();

    // exhaustive back-to-back stream
    for (int ar = 0; ar < 2; ar++)
      for (int s = 0; s < 8; s++)
        for (int a = 0; a < 256; a++)
          send(a[7:0], s[2:0], ar[0],
               model(a[7:0], s[2:0], ar[0]));
    idle(1);
    drain();

    // random backpressure and random up_valid gaps
    bp_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0]  a;
      logic [SW-1:0] s;
      logic          ar;
      a  = N'($urandom);
      s  = SW'($urandom);
      ar = 1'($urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(a, s, ar, model(a, s, ar));
    end
    idle(1);
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    drain();

    // asynchronous reset with three requests in flight
    send(8'h11, 3'd1, 1'b0, 8'h08);
    send(8'h22, 3'd1, 1'b0, 8'h11);
    send(8'h44, 3'd1, 1'b0, 8'h22);
    bus.up_valid = 1'b0;
    #1;
    chk("pre_rst_valid", {31'd0, bus.down_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, bus.down_valid}, 0);
    chk("async_rst_ready", {31'd0, bus.up_ready}, 1);
    q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h80, 3'd1, 1'b0, 8'h40);
    idle(1);
    drain();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
